// File: rtl/io_input_conditioner.sv
// Board input front end: synchronises button/switch pins, debounces the button,
// captures the switches on each confirmed press and holds it under a valid/ack handshake.
module io_input_conditioner #(
  parameter int SW_WIDTH        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                press_ack,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic                btn_level,
  output logic                btn_pulse,
  output logic                press_valid,
  output logic [SW_WIDTH-1:0] sw_latched,
  output logic                overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]               btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q, sw_sync_d;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                btn_level_q, btn_level_d;
  logic                btn_pulse_q, btn_pulse_d;
  logic                press_valid_q, press_valid_d;
  logic [SW_WIDTH-1:0] sw_latched_q, sw_latched_d;
  logic                overrun_q, overrun_d;

  logic                btn_s;
  logic [SW_WIDTH-1:0] sw_s;
  logic                confirm;

  assign btn_s   = btn_sync_q[SYNC_STAGES-1];
  assign sw_s    = sw_sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    btn_sync_d   = {btn_sync_q[SYNC_STAGES-2:0], button};
    sw_sync_d    = sw_sync_q;
    sw_sync_d[0] = switches;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sw_sync_d[i] = sw_sync_q[i-1];
    end
  end

  // Debounce FSM: the counter restarts on every state change, so a single
  // opposing sample anywhere in the window sends the check back to its origin.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    confirm = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
          confirm = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        cnt_d = CNT_ZERO;
        if (!btn_s) begin
          state_d = REL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      REL_CHK: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // A press confirmed while the previous one is still unconsumed is dropped,
  // unless the consumer acks on that very edge and frees the slot.
  always_comb begin
    btn_level_d   = (state_d == PRESSED) || (state_d == REL_CHK);
    btn_pulse_d   = confirm;
    press_valid_d = press_valid_q;
    sw_latched_d  = sw_latched_q;
    overrun_d     = overrun_q;
    if (confirm) begin
      if (!press_valid_q || press_ack) begin
        press_valid_d = 1'b1;
        sw_latched_d  = sw_s;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (press_valid_q && press_ack) begin
      press_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_sync_q    <= '0;
      sw_sync_q     <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      btn_level_q   <= 1'b0;
      btn_pulse_q   <= 1'b0;
      press_valid_q <= 1'b0;
      sw_latched_q  <= '0;
      overrun_q     <= 1'b0;
    end else begin
      btn_sync_q    <= btn_sync_d;
      sw_sync_q     <= sw_sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_level_q   <= btn_level_d;
      btn_pulse_q   <= btn_pulse_d;
      press_valid_q <= press_valid_d;
      sw_latched_q  <= sw_latched_d;
      overrun_q     <= overrun_d;
    end
  end

  assign sw_sync     = sw_s;
  assign btn_level   = btn_level_q;
  assign btn_pulse   = btn_pulse_q;
  assign press_valid = press_valid_q;
  assign sw_latched  = sw_latched_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_io_input_conditioner;

  localparam int SW_WIDTH = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                button = 1'b0;
  logic [SW_WIDTH-1:0] switches = '0;
  logic                press_ack = 1'b0;
  logic [SW_WIDTH-1:0] sw_sync;
  logic                btn_level;
  logic                btn_pulse;
  logic                press_valid;
  logic [SW_WIDTH-1:0] sw_latched;
  logic                overrun;

  int n_checks = 0;
  int n_fail   = 0;

  io_input_conditioner #(
    .SW_WIDTH       (SW_WIDTH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .switches   (switches),
    .press_ack  (press_ack),
    .sw_sync    (sw_sync),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .press_valid(press_valid),
    .sw_latched (sw_latched),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_release();
    button = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; button = 1'b1; switches = 8'hFF;
    repeat (3) tick();
    n_checks++;
    if ({sw_sync, btn_level, btn_pulse, press_valid, sw_latched, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sw_sync=%h lvl=%b pulse=%b valid=%b latched=%h ovr=%b required all 0",
               sw_sync, btn_level, btn_pulse, press_valid, sw_latched, overrun);
    end
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (btn_pulse !== (k == 6)) begin
        n_fail++;
        $display("FAIL reset_pulse_edge%0d: got %b required %b", k, btn_pulse, (k == 6));
      end
    end
    n_checks++;
    if (sw_latched !== 8'hFF || press_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_capture: got latched=%h valid=%b required FF/1", sw_latched, press_valid);
    end
    tick();
    n_checks++;
    if (btn_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse_width: got %b required 0", btn_pulse);
    end
    press_ack = 1'b1; tick(); press_ack = 1'b0;
    settle_release();
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int seen;
    pat = 8'b0111_0111;
    switches = 8'hA5;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      button = pat[k];
      tick();
      if (btn_pulse === 1'b1 || btn_level === 1'b1) seen++;
    end
    button = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (btn_pulse === 1'b1 || btn_level === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL bounce_no_pulse: got %0d active cycles required 0", seen);
    end
    button = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (btn_pulse !== (k == 6)) begin
        n_fail++;
        $display("FAIL bounce_pulse_edge%0d: got %b required %b", k, btn_pulse, (k == 6));
      end
    end
    n_checks++;
    if (sw_latched !== 8'hA5 || press_valid !== 1'b1 || btn_level !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_capture: got latched=%h valid=%b lvl=%b required A5/1/1",
               sw_latched, press_valid, btn_level);
    end
  endtask

  task automatic test_handshake();
    int drops;
    drops = 0;
    press_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (press_valid !== 1'b1) drops++;
    end
    n_checks++;
    if (drops !== 0) begin
      n_fail++;
      $display("FAIL hs_hold: got %0d cycles with valid=0 required 0", drops);
    end
    press_ack = 1'b1; tick(); press_ack = 1'b0;
    n_checks++;
    if (press_valid !== 1'b0 || sw_latched !== 8'hA5) begin
      n_fail++;
      $display("FAIL hs_ack: got valid=%b latched=%h required 0/A5", press_valid, sw_latched);
    end
    press_ack = 1'b1; tick(); press_ack = 1'b0;
    n_checks++;
    if (press_valid !== 1'b0 || sw_latched !== 8'hA5) begin
      n_fail++;
      $display("FAIL hs_idle_ack: got valid=%b latched=%h required 0/A5", press_valid, sw_latched);
    end
  endtask

  task automatic test_overrun();
    settle_release();
    switches = 8'hA5; button = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (press_valid !== 1'b1 || sw_latched !== 8'hA5 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: got valid=%b latched=%h ovr=%b required 1/A5/0",
               press_valid, sw_latched, overrun);
    end
    settle_release();
    switches = 8'h3C; button = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (btn_pulse !== 1'b1 || press_valid !== 1'b1 || sw_latched !== 8'hA5 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_drop: got pulse=%b valid=%b latched=%h ovr=%b required 1/1/A5/1",
               btn_pulse, press_valid, sw_latched, overrun);
    end
    settle_release();
    button = 1'b1;
    repeat (5) tick();
    press_ack = 1'b1; tick(); press_ack = 1'b0;
    n_checks++;
    if (btn_pulse !== 1'b1 || press_valid !== 1'b1 || sw_latched !== 8'h3C || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_ack_on_confirm: got pulse=%b valid=%b latched=%h ovr=%b required 1/1/3C/1",
               btn_pulse, press_valid, sw_latched, overrun);
    end
  endtask

  task automatic test_release_glitch();
    int bad;
    bad = 0;
    button = 1'b0; tick(); tick();
    button = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (btn_level !== 1'b1 || btn_pulse !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL glitch_hold: got %0d bad cycles required 0", bad);
    end
    button = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (btn_level !== (k < 6)) begin
        n_fail++;
        $display("FAIL release_level_edge%0d: got %b required %b", k, btn_level, (k < 6));
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_mid_debounce_reset();
    button = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (press_valid !== 1'b0 || overrun !== 1'b0 || btn_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got valid=%b ovr=%b pulse=%b required 0/0/0",
               press_valid, overrun, btn_pulse);
    end
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (btn_pulse !== (k == 6)) begin
        n_fail++;
        $display("FAIL mid_reset_pulse_edge%0d: got %b required %b", k, btn_pulse, (k == 6));
      end
    end
    n_checks++;
    if (press_valid !== 1'b1 || sw_latched !== 8'h3C) begin
      n_fail++;
      $display("FAIL mid_reset_capture: got valid=%b latched=%h required 1/3C", press_valid, sw_latched);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_handshake();
    test_overrun();
    test_release_glitch();
    test_mid_debounce_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
